// File: rtl/prio_arbiter.sv
// Registered N-way arbiter: fixed-priority or round-robin, grant held until done/request drop.
// Optional forced release after MAX_HOLD cycles when PRIO_ARB_TIMEOUT_EN is defined.
module prio_arbiter #(
    parameter int N        = 4,
    parameter int IDXW     = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            mode,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    generate
        if (N < 2 || MAX_HOLD < 2) begin : g_bad_param
            $error("prio_arbiter: N and MAX_HOLD must both be >= 2");
        end
    endgenerate

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nx;
    logic [IDXW-1:0] last_idx;
    logic [IDXW-1:0] win;
    logic [IDXW-1:0] pos;
    logic            hit;
    logic            load, rel, rel_req, rel_tmo;

    // Round-robin searches upward from the slot after the previous grantee and wraps.
    always_comb begin
        win = '0;
        hit = 1'b0;
        pos = '0;
        if (mode) begin
            for (int i = 0; i < N; i++) begin
                pos = IDXW'((int'(last_idx) + 1 + i) % N);
                if (!hit && req[pos]) begin
                    win = pos;
                    hit = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++)
                if (req[IDXW'(i)]) win = IDXW'(i);
        end
    end

    assign rel_req = done || !req[gnt_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        rel      = 1'b0;
        case (state)
            IDLE: if (|req) begin
                state_nx = GRANT;
                load     = 1'b1;
            end
            GRANT: if (rel_req || rel_tmo) begin
                state_nx = IDLE;
                rel      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            last_idx  <= IDXW'(N - 1);
        end else if (load) begin
            gnt       <= '0;
            gnt[win]  <= 1'b1;
            gnt_idx   <= win;
            gnt_valid <= 1'b1;
        end else if (rel) begin
            // gnt_idx is left as-is; it is meaningless while gnt_valid is low.
            gnt       <= '0;
            gnt_valid <= 1'b0;
            last_idx  <= gnt_idx;
        end
    end

`ifdef PRIO_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD);
    logic [HW-1:0] hold_cnt;

    assign rel_tmo = (state == GRANT) && !rel_req && (hold_cnt == HW'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= rel_tmo;
            if (state == GRANT && !rel)
                hold_cnt <= (hold_cnt == HW'(MAX_HOLD - 1)) ? hold_cnt : hold_cnt + 1'b1;
            else
                hold_cnt <= '0;
        end
    end
`else
    assign rel_tmo = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_prio_arbiter.sv
// Self-checking bench for prio_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural grant model.
module tb_prio_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
`ifdef PRIO_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req   = '0;
    logic         mode  = 1'b0;
    logic         done  = 1'b0;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_valid;
    logic         timeout;

    int checks   = 0;
    int failures = 0;

    prio_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: who holds the grant, for how long, and who held it last.
    bit m_valid = 0;
    int m_idx   = 0;
    int m_last  = N - 1;
    int m_age   = 0;
    bit m_tmo   = 0;

    function automatic int pick(input logic [N-1:0] r, input logic md, input int last);
        logic [2*N-1:0] dbl;
        int start;
        if (!md) begin
            for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
            return -1;
        end
        start = (last + 1) % N;
        dbl = {r, r} >> start;
        for (int i = 0; i < N; i++) if (dbl[i]) return (start + i) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_idx = 0; m_last = N - 1; m_age = 0; m_tmo = 0;
        end else if (!m_valid) begin
            m_tmo = 0;
            if (req != 0) begin
                m_idx = pick(req, mode, m_last);
                m_valid = 1;
                m_age = 1;
            end
        end else begin
            m_tmo = 0;
            if (done || !req[m_idx]) begin
                m_valid = 0; m_last = m_idx;
            end else if (TMO_EN && m_age >= MAX_HOLD) begin
                m_valid = 0; m_last = m_idx; m_tmo = 1;
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        check("m_valid", gnt_valid, m_valid);
        check("m_gnt", gnt, m_valid ? (32'd1 << m_idx) : 32'd0);
        check("m_timeout", timeout, m_tmo);
        if (m_valid) check("m_idx", gnt_idx, m_idx);
    end

    task automatic wait_grant(input string nm, input int exp);
        bit found = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (gnt_valid) begin found = 1; break; end
        end
        check({nm, "_wait"}, found, 1);
        if (found) begin
            check(nm, gnt_idx, exp);
            check({nm, "_onehot"}, gnt, 32'd1 << exp);
        end
    endtask

    task automatic pulse_done(input string nm);
        @(posedge clk); #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        @(negedge clk);
        check({nm, "_gap"}, gnt_valid, 0);
    endtask

    logic [N-1:0] pats [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1010, 4'b0111, 4'b0011};
    int           fexp [7] = '{0, 1, 2, 3, 3, 2, 1};
    int           rexp [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        int cnt;
        bit tmo_seen;
        req = 4'b1111;
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_valid", gnt_valid, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        wait_grant("rst_first", 3);
        pulse_done("rst_rel");

        for (int i = 0; i < 7; i++) begin
            req = pats[i];
            wait_grant($sformatf("fixed%0d", i), fexp[i]);
            pulse_done($sformatf("fixed%0d", i));
        end

        // Dropping the grantee's request releases without done.
        req = 4'b0110;
        wait_grant("drop_first", 2);
        @(posedge clk); #1 req = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        check("drop_gap", gnt_valid, 0);
        wait_grant("drop_next", 1);
        @(posedge clk); #1 req = '0;
        @(posedge clk); #1 done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_done", gnt_valid, 0);
        end
        @(posedge clk); #1 done = 1'b0; req = 4'b0100;
        wait_grant("after_idle_done", 2);

        // Asynchronous reset in the middle of a grant.
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("async_gnt", gnt, 0);
        check("async_valid", gnt_valid, 0);
        mode = 1'b1;
        req  = 4'b1111;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_grant($sformatf("rr%0d", i), rexp[i]);
            pulse_done($sformatf("rr%0d", i));
        end

        mode = 1'b0;
        req  = 4'b0001;
        wait_grant("hold_first", 0);
        cnt = 1;
        tmo_seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (timeout) tmo_seen = 1;
            if (!gnt_valid) break;
            cnt++;
        end
`ifdef PRIO_ARB_TIMEOUT_EN
        check("tmo_hold_len", cnt, MAX_HOLD);
        check("tmo_pulse", tmo_seen, 1);
        wait_grant("tmo_regrant", 0);
`else
        check("hold_len", cnt, 51);
        check("hold_no_tmo", tmo_seen, 0);
`endif

        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            req  = N'($urandom);
            mode = 1'($urandom);
            done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
